// File: rtl/cnn_stream_ctrl_if.sv
// Frame controller bus: start/busy/done handshake, frame memory read/write ports
// and the link to the cnn datapath.
interface cnn_stream_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          ovf;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;
  logic [DW-1:0] x;
  logic          cnn_rst;
  logic [DW-1:0] y;
  logic          w_en;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] data_w;
  logic          mem_w_en;

  modport master (
    input  start, data_r, y, w_en,
    output busy, done, err, ovf, addr_r, x, cnn_rst, addr_w, data_w, mem_w_en
  );

  modport slave (
    output start, data_r, y, w_en,
    input  busy, done, err, ovf, addr_r, x, cnn_rst, addr_w, data_w, mem_w_en
  );
endinterface

// File: rtl/cnn_stream_ctrl.sv
// Streams one frame from memory into the cnn and writes its results back.
// Optional drain timeout is enabled by defining CNN_CTRL_TIMEOUT_EN.
module cnn_stream_ctrl #(
  parameter int IMG_W     = 9,
  parameter int IMG_H     = 9,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_BASE   = 0,
  parameter int WR_BASE   = 128,
  parameter int OUT_COUNT = 49,
  parameter int DRAIN_MAX = 32
) (
  input  logic                clk,
  input  logic                rst,
  cnn_stream_ctrl_if.master   bus
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int RCW  = $clog2(NPIX + 1);
  localparam int WCW  = $clog2(OUT_COUNT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state_reg;
  logic [RCW-1:0] rd_cnt_reg;
  logic [WCW-1:0] wr_cnt_reg;
  logic [AW-1:0]  addr_r_reg;
  logic [AW-1:0]  addr_w_reg;
  logic           ovf_reg;
  logic           active;
  logic           wr_full;
  logic           mem_w_en;
  logic           timeout;

  assign active   = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign wr_full  = (wr_cnt_reg == WCW'(OUT_COUNT));
  assign mem_w_en = bus.w_en && active && !wr_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      addr_r_reg <= AW'(RD_BASE);
      addr_w_reg <= AW'(WR_BASE);
      ovf_reg    <= 1'b0;
    end else begin
      if (mem_w_en) begin
        wr_cnt_reg <= wr_cnt_reg + WCW'(1);
        addr_w_reg <= addr_w_reg + AW'(1);
      end
      // Results beyond the expected count are dropped but remembered.
      if (bus.w_en && active && wr_full) begin
        ovf_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg  <= S_STREAM;
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
            addr_r_reg <= AW'(RD_BASE);
            addr_w_reg <= AW'(WR_BASE);
            ovf_reg    <= 1'b0;
          end
        end
        S_STREAM: begin
          if (rd_cnt_reg == RCW'(NPIX - 1)) begin
            state_reg <= S_DRAIN;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + RCW'(1);
            addr_r_reg <= addr_r_reg + AW'(1);
          end
        end
        S_DRAIN: begin
          if (wr_full || timeout) begin
            state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef CNN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_MAX + 1);

  logic [TW-1:0] drain_cnt_reg;
  logic          err_reg;

  assign timeout = (state_reg == S_DRAIN) && !wr_full &&
                   (drain_cnt_reg == TW'(DRAIN_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      drain_cnt_reg <= (state_reg == S_DRAIN) ? drain_cnt_reg + TW'(1) : '0;
      if (state_reg == S_IDLE && bus.start) begin
        err_reg <= 1'b0;
      end else if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.err = err_reg;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.busy     = active;
  assign bus.done     = (state_reg == S_DONE);
  assign bus.ovf      = ovf_reg;
  assign bus.cnn_rst  = !active;
  assign bus.addr_r   = addr_r_reg;
  assign bus.x        = bus.data_r;
  assign bus.addr_w   = addr_w_reg;
  assign bus.data_w   = bus.y;
  assign bus.mem_w_en = mem_w_en;

endmodule

// File: doc/cnn_stream_ctrl.md
Name: cnn_stream_ctrl

Overview:
Frame-level controller that drives the cnn datapath from frame memory: generates read addresses and streams one pixel per clock into the cnn `x` input. It captures every cnn result qualified by `w_en` and writes it back to memory at an output base address. It replaces the hand-driven address sequencing with a start/busy/done handshake, so a frame can be processed without bench intervention.

Parameters:
- IMG_W, 9, image width in pixels
- IMG_H, 9, image height in pixels
- AW, 8, memory address width
- DW, 8, pixel/result data width
- RD_BASE, 0, first input pixel address
- WR_BASE, 128, first result address
- OUT_COUNT, 49, expected results per frame ((IMG_W-2)*(IMG_H-2))
- DRAIN_MAX, 32, drain timeout in cycles (used only with CNN_CTRL_TIMEOUT_EN)

Ports:
- clk, input, 1, clock; all state updates on rising edge
- rst, input, 1, asynchronous active-high reset
- start, input, 1, frame start request; sampled in IDLE only
- busy, output, 1, high in STREAM and DRAIN
- done, output, 1, one-cycle pulse at frame end
- err, output, 1, frame ended on timeout; valid with done, held until next start
- ovf, output, 1, sticky: cnn_w_en seen after OUT_COUNT results; cleared on start
- addr_r, output, AW, memory read address
- data_r, input, DW, memory read data (combinational read of addr_r)
- x, output, DW, pixel to cnn; combinational copy of data_r
- cnn_rst, output, 1, reset to cnn; high except in STREAM/DRAIN
- y, input, DW, cnn result
- w_en, input, 1, cnn result valid
- addr_w, output, AW, memory write address
- data_w, output, DW, memory write data; equals y
- mem_w_en, output, 1, memory write enable

Behaviour:
- Reset (async, rst=1): state=IDLE, addr_r=RD_BASE, addr_w=WR_BASE, rd_cnt=0, wr_cnt=0, busy=0, done=0, err=0, ovf=0, cnn_rst=1, mem_w_en=0.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 -> STREAM next edge.
  - On that edge: addr_r=RD_BASE, addr_w=WR_BASE, counters cleared, err and ovf cleared.
- STREAM:
  - cnn_rst=0.
  - addr_r increments by 1 every cycle; the cycle after entry presents RD_BASE.
  - After IMG_W*IMG_H addresses (RD_BASE..RD_BASE+80 by default), state -> DRAIN. addr_r holds its last value.
- DRAIN:
  - cnn_rst=0.
  - Waits for wr_cnt==OUT_COUNT, then -> DONE.
- DONE: done=1 for exactly one cycle, cnn_rst=1, then -> IDLE.
- Write path:
  - mem_w_en = w_en AND (STREAM or DRAIN) AND wr_cnt<OUT_COUNT (combinational).
  - addr_w = registered WR_BASE+wr_cnt.
  - On each edge with mem_w_en=1: wr_cnt++ and addr_w++.
- w_en with wr_cnt==OUT_COUNT: no write, ovf<=1.
- w_en outside STREAM/DRAIN: ignored; no write, no flag.
- Address arithmetic is modulo 2^AW. addr_r and addr_w wrap silently (e.g. WR_BASE=250 wraps 255->0).
- start while busy or in DONE: ignored.
- start held high continuously: a new frame begins on the cycle after DONE.
- If wr_cnt reaches OUT_COUNT during STREAM, the block still finishes streaming all pixels before DONE.
- Reset mid-frame: immediate return to reset values. No partial done, and no write is issued after rst rises.

Optional Feature:
- Macro: CNN_CTRL_TIMEOUT_EN.
- Defined: DRAIN counts cycles from entry. If DRAIN_MAX cycles elapse with wr_cnt<OUT_COUNT, state -> DONE with err=1. err holds until the next accepted start.
- Not defined: DRAIN waits indefinitely, err is tied to 0, and no timeout counter is synthesized.

Test Plan:
- Nominal frame: memory 0..80 random, cnn weights 219/181/130/201/81/34/63/11/199, start pulse -> addr_r runs 0..80 one per cycle; exactly 49 writes to 128..176; done pulses once; err=0, ovf=0.
- Reset mid-frame: assert rst during STREAM at addr_r=40 -> same-cycle return to addr_r=0, busy=0, cnn_rst=1, no further mem_w_en. A new start then gives a full 49-write frame.
- Overflow: bench forces 50 w_en pulses -> writes 128..176 only; 50th pulse produces no write and ovf=1; ovf clears on next start.
- Start while busy: pulse start at addr_r=10 -> no restart; addr_r continues to 80; single done.
- Address wrap: WR_BASE=250 -> results at 250..255 then 0..42; 49 writes total.
- Timeout (CNN_CTRL_TIMEOUT_EN, DRAIN_MAX=32): w_en stuck low -> DONE 32 cycles after DRAIN entry; done=1 with err=1. Without the macro: busy stays high indefinitely.
